// File: rtl/dac_interp_feeder_if.sv
// dac_interp_feeder_if: sample-in handshake and interpolated sample-out bus of the DAC feeder
interface dac_interp_feeder_if;
  logic        in_valid;
  logic        in_ready;
  logic [23:0] in_l;
  logic [23:0] in_r;
  logic        out_valid;
  logic [23:0] out_l;
  logic [23:0] out_r;
  modport slave (
    input  in_valid, in_l, in_r,
    output in_ready, out_valid, out_l, out_r
  );
  modport master (
    output in_valid, in_l, in_r,
    input  in_ready, out_valid, out_l, out_r
  );
endinterface

// File: rtl/dac_interp_feeder.sv
// dac_interp_feeder: stereo PCM FIFO + linear interpolator feeding a sigma-delta DAC; optional LSB dither via DAC_INTERP_DITHER_EN
module dac_interp_feeder #(
  parameter int DEPTH    = 4,
  parameter int OSR_LOG2 = 6,
  parameter int DIV      = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     enable,
  input  logic                     clear_underrun,
  output logic                     underrun,
  output logic [$clog2(DEPTH):0]   fifo_level,
  dac_interp_feeder_if.slave       bus
);
  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;
  localparam int TW = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int PW = 25 + OSR_LOG2;
  typedef enum logic {IDLE, RUN} state_t;
  state_t                state_q, state_n;
  logic [TW-1:0]         t_q, t_n;
  logic [OSR_LOG2-1:0]   k_q, k_n, k_eff;
  logic                  tick, seg, wr, pop;
  logic [47:0]           mem [DEPTH];
  logic [AW-1:0]         wptr, rptr;
  logic [23:0]           prev_l, prev_r, cur_l, cur_r;
  logic [23:0]           prev_l_n, prev_r_n, cur_l_n, cur_r_n;
  logic [23:0]           ol_n, or_n, ol_q, or_q;
  logic                  ov_q;
  function automatic logic [23:0] interp(input logic [23:0] p, input logic [23:0] c,
                                         input logic [OSR_LOG2-1:0] k);
    logic [24:0]   d;
    logic [PW-1:0] prod;
    d    = {c[23], c} - {p[23], p};
    prod = {{OSR_LOG2{d[24]}}, d} * {25'd0, k};
    return p + 24'($signed(prod) >>> OSR_LOG2);
  endfunction
  assign bus.in_ready  = fifo_level != LW'(DEPTH);
  assign bus.out_valid = ov_q;
  assign bus.out_l     = ol_q;
  assign bus.out_r     = or_q;
  // run/idle state tracks enable one cycle late; IDLE zeroes the phase seen by the next tick
  always_ff @(posedge clk or posedge rst)
    if (rst) state_q <= IDLE;
    else state_q <= state_n;
  // tick pacing, phase, segment advance and FIFO handshake decisions
  always_comb begin
    state_n  = enable ? RUN : IDLE;
    k_eff    = (state_q == IDLE) ? '0 : k_q;
    tick     = enable && (t_q == TW'(DIV - 1));
    t_n      = (!enable || tick) ? '0 : t_q + TW'(1);
    k_n      = tick ? k_eff + OSR_LOG2'(1) : k_eff;
    seg      = tick && (k_eff == '0);
    pop      = seg && (fifo_level != '0);
    wr       = bus.in_valid && bus.in_ready;
    prev_l_n = seg ? cur_l : prev_l;
    prev_r_n = seg ? cur_r : prev_r;
    cur_l_n  = pop ? mem[rptr][47:24] : cur_l;
    cur_r_n  = pop ? mem[rptr][23:0] : cur_r;
  end
`ifdef DAC_INTERP_DITHER_EN
  logic [15:0] lfsr;
  logic [23:0] il, ir;
  // one LFSR step per tick; bit0/bit1 dither the L/R LSB with saturation at full scale
  always_ff @(posedge clk or posedge rst)
    if (rst) lfsr <= 16'hACE1;
    else if (tick) lfsr <= {lfsr[14:0], lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10]};
  // interpolated value plus dither LSB, clamped so +1 never wraps the positive rail
  always_comb begin
    il   = interp(prev_l_n, cur_l_n, k_eff);
    ir   = interp(prev_r_n, cur_r_n, k_eff);
    ol_n = (lfsr[0] && il == 24'h7FFFFF) ? il : il + {23'd0, lfsr[0]};
    or_n = (lfsr[1] && ir == 24'h7FFFFF) ? ir : ir + {23'd0, lfsr[1]};
  end
`else
  // plain interpolation from the post-advance prev/cur at this tick's phase
  always_comb begin
    ol_n = interp(prev_l_n, cur_l_n, k_eff);
    or_n = interp(prev_r_n, cur_r_n, k_eff);
  end
`endif
  // counters, FIFO pointers/level and segment registers
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      t_q        <= '0;
      k_q        <= '0;
      wptr       <= '0;
      rptr       <= '0;
      fifo_level <= '0;
      prev_l     <= '0;
      prev_r     <= '0;
      cur_l      <= '0;
      cur_r      <= '0;
    end else begin
      t_q        <= t_n;
      k_q        <= k_n;
      wptr       <= wr ? wptr + AW'(1) : wptr;
      rptr       <= pop ? rptr + AW'(1) : rptr;
      fifo_level <= fifo_level + LW'(wr) - LW'(pop);
      prev_l     <= prev_l_n;
      prev_r     <= prev_r_n;
      cur_l      <= cur_l_n;
      cur_r      <= cur_r_n;
    end
  // sample storage; contents need no reset since level gates every read
  always_ff @(posedge clk)
    if (wr) mem[wptr] <= {bus.in_l, bus.in_r};
  // sticky underrun: a starved segment start beats a same-cycle clear
  always_ff @(posedge clk or posedge rst)
    if (rst) underrun <= 1'b0;
    else underrun <= (seg && fifo_level == '0) ? 1'b1 : (clear_underrun ? 1'b0 : underrun);
  // output strobe and held sample values, updated one cycle after each tick
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      ov_q <= 1'b0;
      ol_q <= '0;
      or_q <= '0;
    end else begin
      ov_q <= tick;
      ol_q <= tick ? ol_n : ol_q;
      or_q <= tick ? or_n : or_q;
    end
endmodule

// File: tb/tb_dac_interp_feeder.sv
// tb_dac_interp_feeder: randomized + directed checks of the DAC interpolating feeder against a queue-based model
module tb_dac_interp_feeder;
  localparam int DEPTH = 4;
  localparam int OSR   = 4;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic en_a = 1'b0, clr_a = 1'b0, und_a;
  logic en_b = 1'b0, clr_b = 1'b0, und_b;
  logic [2:0] lvl_a, lvl_b;
  int vectors = 0, miscompares = 0;
  int q_l[$], q_r[$];
  int m_prev_l, m_cur_l, m_prev_r, m_cur_r, m_k, m_ol, m_or;
  bit m_und, m_ov;
  always #5 clk = ~clk;
  dac_interp_feeder_if bus_a();
  dac_interp_feeder_if bus_b();
  dac_interp_feeder #(.DEPTH(DEPTH), .OSR_LOG2(2), .DIV(1)) dut_a (
    .clk(clk), .rst(rst), .enable(en_a), .clear_underrun(clr_a),
    .underrun(und_a), .fifo_level(lvl_a), .bus(bus_a));
  dac_interp_feeder #(.DEPTH(DEPTH), .OSR_LOG2(2), .DIV(4)) dut_b (
    .clk(clk), .rst(rst), .enable(en_b), .clear_underrun(clr_b),
    .underrun(und_b), .fifo_level(lvl_b), .bus(bus_b));
  function automatic int sx(logic [23:0] v);
    return int'($signed(v));
  endfunction
  function automatic int interp_m(int p, int c, int k);
    longint n, f;
    n = longint'(c - p) * k;
    f = n / OSR;
    if (n < 0 && n % OSR != 0) f = f - 1;
    return int'(longint'(p) + f);
  endfunction
  task automatic model_reset();
    q_l.delete();
    q_r.delete();
    {m_prev_l, m_cur_l, m_prev_r, m_cur_r, m_k, m_ol, m_or} = '0;
    m_und = 0;
    m_ov  = 0;
  endtask
  task automatic do_reset();
    en_a = 0; en_b = 0; clr_a = 0; clr_b = 0;
    bus_a.in_valid = 0; bus_b.in_valid = 0;
    @(negedge clk) rst = 1;
    @(negedge clk) rst = 0;
    model_reset();
  endtask
  task automatic cyc(input bit en, input bit v, input int l, input int r, input bit clr);
    bit wr, set;
    logic [23:0] el, er;
    en_a = en; bus_a.in_valid = v; bus_a.in_l = l[23:0]; bus_a.in_r = r[23:0]; clr_a = clr;
    wr  = v && q_l.size() < DEPTH;
    set = 0;
    m_ov = en;
    if (en) begin
      if (m_k == 0) begin
        m_prev_l = m_cur_l;
        m_prev_r = m_cur_r;
        if (q_l.size() > 0) begin
          m_cur_l = q_l.pop_front();
          m_cur_r = q_r.pop_front();
        end else set = 1;
      end
      m_ol = interp_m(m_prev_l, m_cur_l, m_k);
      m_or = interp_m(m_prev_r, m_cur_r, m_k);
      m_k  = (m_k + 1) % OSR;
    end else m_k = 0;
    m_und = set ? 1'b1 : (clr ? 1'b0 : m_und);
    if (wr) begin
      q_l.push_back(sx(l[23:0]));
      q_r.push_back(sx(r[23:0]));
    end
    @(posedge clk); #1;
    el = m_ol[23:0];
    er = m_or[23:0];
    vectors++;
    if (lvl_a !== 3'(q_l.size())) begin miscompares++; $display("FAIL level: got %0d want %0d", lvl_a, q_l.size()); end
    vectors++;
    if (bus_a.in_ready !== (q_l.size() < DEPTH)) begin miscompares++; $display("FAIL in_ready: got %b want %b", bus_a.in_ready, q_l.size() < DEPTH); end
    vectors++;
    if (und_a !== m_und) begin miscompares++; $display("FAIL underrun: got %b want %b", und_a, m_und); end
    vectors++;
    if (bus_a.out_valid !== m_ov) begin miscompares++; $display("FAIL out_valid: got %b want %b", bus_a.out_valid, m_ov); end
    if (m_ov) begin
      vectors++;
      if (bus_a.out_l !== el) begin miscompares++; $display("FAIL out_l: got %h want %h", bus_a.out_l, el); end
      vectors++;
      if (bus_a.out_r !== er) begin miscompares++; $display("FAIL out_r: got %h want %h", bus_a.out_r, er); end
    end
  endtask
  task automatic test_reset();
    repeat (2) @(negedge clk);
    rst = 0;
    model_reset();
    vectors++;
    if (lvl_a !== 3'd0 || bus_a.in_ready !== 1'b1 || bus_a.out_valid !== 1'b0 || und_a !== 1'b0)
      begin miscompares++; $display("FAIL reset_init: level %0d rdy %b ov %b und %b", lvl_a, bus_a.in_ready, bus_a.out_valid, und_a); end
    for (int i = 0; i < 7; i++) cyc(1, 1, 1000, -2000, 0);
    en_a = 0; bus_a.in_valid = 0;
    #2 rst = 1;
    #1;
    vectors++;
    if (bus_a.out_valid !== 1'b0 || bus_a.out_l !== 24'd0 || bus_a.out_r !== 24'd0)
      begin miscompares++; $display("FAIL reset_out: ov %b l %h r %h want 0", bus_a.out_valid, bus_a.out_l, bus_a.out_r); end
    vectors++;
    if (lvl_a !== 3'd0 || bus_a.in_ready !== 1'b1 || und_a !== 1'b0)
      begin miscompares++; $display("FAIL reset_fifo: level %0d rdy %b und %b want 0 1 0", lvl_a, bus_a.in_ready, und_a); end
    @(negedge clk) rst = 0;
    model_reset();
  endtask
  task automatic test_fill();
    do_reset();
    for (int i = 0; i < 5; i++) cyc(0, 1, 10 * (i + 1), -(i + 1), 0);
    vectors++;
    if (lvl_a !== 3'd4 || bus_a.in_ready !== 1'b0)
      begin miscompares++; $display("FAIL fill: level %0d rdy %b want 4 0", lvl_a, bus_a.in_ready); end
  endtask
  task automatic test_interp();
    int exp_l [12];
    exp_l = '{0, 0, 0, 0, 0, 100, 200, 300, 400, 400, 400, 400};
    do_reset();
    cyc(0, 1, 0, 5, 0);
    cyc(0, 1, 400, 7, 0);
    for (int i = 0; i < 12; i++) begin
      cyc(1, 0, 0, 0, 0);
      vectors++;
      if (bus_a.out_l !== 24'(exp_l[i]))
        begin miscompares++; $display("FAIL interp[%0d]: got %0d want %0d", i, sx(bus_a.out_l), exp_l[i]); end
      vectors++;
      if (und_a !== (i >= 8))
        begin miscompares++; $display("FAIL interp_und[%0d]: got %b want %b", i, und_a, i >= 8); end
    end
    cyc(0, 0, 0, 0, 0);
  endtask
  task automatic test_negative();
    int exp_l [4];
    exp_l = '{100, 50, 0, -50};
    do_reset();
    cyc(0, 1, 100, -8388608, 0);
    cyc(0, 1, -100, 8388607, 0);
    for (int i = 0; i < 8; i++) begin
      cyc(1, 0, 0, 0, 0);
      if (i >= 4) begin
        vectors++;
        if (bus_a.out_l !== 24'(exp_l[i-4]))
          begin miscompares++; $display("FAIL neg_l[%0d]: got %h want %h", i, bus_a.out_l, 24'(exp_l[i-4])); end
      end
      if (i == 6) begin
        vectors++;
        if (bus_a.out_r !== 24'hFFFFFF)
          begin miscompares++; $display("FAIL neg_r_mid: got %h want ffffff", bus_a.out_r); end
      end
    end
    cyc(0, 0, 0, 0, 0);
  endtask
  task automatic test_simultaneous();
    do_reset();
    cyc(0, 1, 11, 22, 0);
    cyc(0, 1, 33, 44, 0);
    cyc(1, 1, 55, 66, 0);
    vectors++;
    if (lvl_a !== 3'd2) begin miscompares++; $display("FAIL push_pop_level: got %0d want 2", lvl_a); end
    cyc(0, 0, 0, 0, 0);
    do_reset();
    cyc(1, 0, 0, 0, 1);
    vectors++;
    if (und_a !== 1'b1) begin miscompares++; $display("FAIL set_beats_clear: got %b want 1", und_a); end
    cyc(0, 0, 0, 0, 1);
    vectors++;
    if (und_a !== 1'b0) begin miscompares++; $display("FAIL clear_underrun: got %b want 0", und_a); end
  endtask
  task automatic test_random();
    logic [23:0] l, r;
    do_reset();
    for (int i = 0; i < 400; i++) begin
      l = 24'($urandom);
      r = 24'($urandom);
      cyc($urandom_range(0, 9) != 0, $urandom_range(0, 4) == 0, sx(l), sx(r), $urandom_range(0, 15) == 0);
    end
    cyc(0, 0, 0, 0, 0);
  endtask
  task automatic push_b(input int l);
    bus_b.in_valid = 1; bus_b.in_l = l[23:0]; bus_b.in_r = 24'd0;
    @(posedge clk); #1;
    bus_b.in_valid = 0;
  endtask
  task automatic test_pacing();
    int cnt, last, seen;
    do_reset();
    cnt = 0; last = -1;
    en_b = 1;
    for (int c = 1; c <= 70; c++) begin
      @(posedge clk); #1;
      if (bus_b.out_valid) begin
        if (last >= 0) begin
          vectors++;
          if (c - last != 4) begin miscompares++; $display("FAIL strobe_gap: got %0d want 4", c - last); end
        end
        cnt++;
        last = c;
      end
      if (c == 64) en_b = 0;
    end
    vectors++;
    if (cnt != 16) begin miscompares++; $display("FAIL strobe_count: got %0d want 16", cnt); end
    do_reset();
    push_b(0); push_b(400); push_b(800);
    en_b = 1;
    seen = 0;
    for (int c = 0; c < 40 && seen < 6; c++) begin
      @(posedge clk); #1;
      if (bus_b.out_valid) seen++;
    end
    vectors++;
    if (seen != 6 || bus_b.out_l !== 24'd100)
      begin miscompares++; $display("FAIL pace_pre: strobes %0d out_l %0d want 6 100", seen, sx(bus_b.out_l)); end
    repeat (2) @(posedge clk);
    #1 en_b = 0;
    for (int c = 0; c < 6; c++) begin
      @(posedge clk); #1;
      vectors++;
      if (bus_b.out_valid !== 1'b0) begin miscompares++; $display("FAIL idle_strobe: got %b want 0", bus_b.out_valid); end
    end
    en_b = 1;
    seen = 0;
    for (int c = 1; c <= 10 && seen == 0; c++) begin
      @(posedge clk); #1;
      if (bus_b.out_valid) seen = c;
    end
    vectors++;
    if (seen != 4 || bus_b.out_l !== 24'd400)
      begin miscompares++; $display("FAIL k_restart: edge %0d out_l %0d want 4 400", seen, sx(bus_b.out_l)); end
    en_b = 0;
  endtask
  initial begin
    bus_a.in_valid = 0; bus_a.in_l = '0; bus_a.in_r = '0;
    bus_b.in_valid = 0; bus_b.in_l = '0; bus_b.in_r = '0;
    test_reset();
    test_fill();
    test_interp();
    test_negative();
    test_simultaneous();
    test_random();
    test_pacing();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule

// File: doc/dac_interp_feeder.md
Name: dac_interp_feeder

Overview:
- Stereo sample feeder that sits directly upstream of the sigma-delta DAC core.
- Buffers 24-bit L/R PCM samples arriving at base rate (valid/ready) in a small FIFO.
- Emits linearly interpolated samples at OSR x base rate as single-cycle out_valid strobes driving the DAC core's in_valid/in_l/in_r.
- Flags FIFO underrun and holds the last sample instead of glitching.

Parameters:
- DEPTH, 4, FIFO depth in stereo samples; power of 2, >=2.
- OSR_LOG2, 6, log2 of interpolation ratio (OSR = 64 default).
- DIV, 4, clk cycles per output tick; >=1.

Ports:
- clk  in  1  system clock.
- rst  in  1  asynchronous active-high reset.
- enable  in  1  run interpolator; low = idle.
- in_valid  in  1  upstream sample valid.
- in_ready  out  1  FIFO can accept a sample.
- in_l  in  24  left PCM, two's complement.
- in_r  in  24  right PCM, two's complement.
- out_valid  out  1  one-cycle strobe, interpolated sample valid.
- out_l  out  24  interpolated left.
- out_r  out  24  interpolated right.
- underrun  out  1  sticky: segment advance found FIFO empty.
- clear_underrun  in  1  synchronous clear of underrun.
- fifo_level  out  clog2(DEPTH)+1  current FIFO occupancy.

Behaviour:
- Reset (async, rst=1): FIFO empty, pointers 0, fifo_level=0, in_ready=1, out_valid=0, out_l=out_r=0, underrun=0, prev/cur regs 0, tick and phase counters 0, state IDLE.
- FIFO: write when in_valid && in_ready; in_ready = (fifo_level != DEPTH), no write-through when full. Pointers wrap modulo DEPTH. Simultaneous write and pop: level unchanged.
- States: IDLE (enable=0): tick counter t and phase k forced to 0, out_valid=0, prev/cur held, FIFO still accepts writes. RUN (enable=1): t counts 0..DIV-1 and wraps; tick asserted when t==DIV-1 (every clk when DIV=1). enable falling -> IDLE next cycle. A tick in flight is discarded, no out_valid.
- On each tick, k increments modulo 2^OSR_LOG2.
- Segment advance on a tick with k==0: prev<=cur.
  - FIFO non-empty: pop into cur.
  - FIFO empty: cur unchanged (hold), underrun<=1.
- Output: registered one clk after the tick, using prev/cur after any advance.
  - diff = cur - prev, 25-bit signed.
  - prod = diff * k, 25+OSR_LOG2 bits signed, k unsigned.
  - out = prev + (prod >>> OSR_LOG2), arithmetic shift (floor); result always between prev and cur, fits 24 bits.
  - out_valid=1 for exactly that cycle.
- Latency: a sample popped at segment start is reached at the following segment start (OSR ticks later).
- clear_underrun and a new underrun in the same cycle: set wins.
- L and R always share k, advance and underrun.

Optional Feature:
- Macro DAC_INTERP_DITHER_EN.
- Defined:
  - 16-bit Fibonacci LFSR (taps 16,14,13,11; reset seed 16'hACE1) advances once per tick.
  - LFSR bit0 added as +0/+1 LSB to out_l; bit1 added to out_r.
  - Saturate at 24'h7FFFFF.
- Undefined: no LFSR, output exactly as specified above.

Test Plan:
- Reset: assert rst mid-stream -> same cycle out_valid=0, out_l=out_r=0, fifo_level=0, in_ready=1, underrun=0.
- Fill: enable=0, DEPTH=4, push 5 samples back-to-back -> in_ready low after 4th accept, fifo_level=4, 5th not stored.
- Interpolation: OSR_LOG2=2, DIV=1, push L=0 then L=400, enable -> out_l = 0,0,0,0 then 0,100,200,300 then 400,400,400,400; underrun=1 at third segment start.
- Negative slope: prev L=100, cur L=-100, OSR 4 -> out_l = 100,50,0,-50 (24'hFFFFCE); R with prev=-8388608, cur=8388607 -> no overflow, out at k=2 = -1.
- Simultaneous: level=2, push and segment pop on same cycle -> level stays 2. clear_underrun with new underrun same cycle -> underrun stays 1.
- Pacing: DIV=4, enable held 64 clks -> exactly 16 out_valid strobes, 4 clks apart. Drop enable mid-count -> no further strobes, k restarts at 0 on re-enable.
